// File: rtl/sd_spi_pkg.sv
// Shared constants, state encodings and the CMD17 frame helper for the SD-over-SPI sector reader.
package sd_spi_pkg;
  localparam logic [7:0] SPI_ADDR_CS   = 8'h04;
  localparam logic [7:0] SPI_ADDR_DATA = 8'h08;
  localparam logic [7:0] CMD17         = 8'h51;
  localparam logic [7:0] CMD17_CRC     = 8'h01;
  localparam logic [7:0] TOKEN_START   = 8'hFE;
  localparam logic [7:0] IDLE_BYTE     = 8'hFF;

  localparam logic [2:0] ERR_OK            = 3'd0;
  localparam logic [2:0] ERR_R1_TIMEOUT    = 3'd1;
  localparam logic [2:0] ERR_R1_BAD        = 3'd2;
  localparam logic [2:0] ERR_TOKEN_BAD     = 3'd3;
  localparam logic [2:0] ERR_TOKEN_TIMEOUT = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_CS_ON, S_PRE, S_CMD, S_R1, S_TOKEN, S_DATA,
    S_HOLD, S_CRC, S_CS_OFF, S_TAIL, S_FIN
  } state_e;

  typedef enum logic [2:0] {X_IDLE, X_WR, X_GAP, X_RD, X_CS} xfer_state_e;

  // Byte idx of the 6-byte CMD17 frame: opcode, 4 argument bytes MSB first, CRC/stop.
  function automatic logic [7:0] cmd17_byte(input logic [2:0] idx, input logic [31:0] arg);
    case (idx)
      3'd0:    return CMD17;
      3'd1:    return arg[31:24];
      3'd2:    return arg[23:16];
      3'd3:    return arg[15:8];
      3'd4:    return arg[7:0];
      default: return CMD17_CRC;
    endcase
  endfunction
endpackage

// File: rtl/sd_spi_byte_xfer.sv
// Drives the SPI controller register port: one full-duplex byte (data write then read back)
// or a single chip-select register write. rx_valid_o pulses when either finishes.
import sd_spi_pkg::*;

module sd_spi_byte_xfer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [7:0]  tx_i,
  input  logic        cs_start_i,
  input  logic [31:0] cs_val_i,
  output logic [7:0]  rx_o,
  output logic        rx_valid_o,
  output logic        spi_wr_o,
  output logic        spi_rd_o,
  output logic [7:0]  spi_addr_o,
  output logic [31:0] spi_wdat_o,
  input  logic [31:0] spi_rdat_i,
  input  logic        spi_done_i
);
  xfer_state_e xs_q, xs_d;
  logic        wr_q, wr_d, rd_q, rd_d, rxv_q, rxv_d;
  logic [7:0]  addr_q, addr_d, rx_q, rx_d;
  logic [31:0] wdat_q, wdat_d;
  logic        unused_rdat;

  assign unused_rdat = ^spi_rdat_i[31:8];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      xs_q <= X_IDLE; wr_q <= 1'b0; rd_q <= 1'b0; rxv_q <= 1'b0;
      addr_q <= 8'h00; wdat_q <= 32'h0; rx_q <= 8'h00;
    end else begin
      xs_q <= xs_d; wr_q <= wr_d; rd_q <= rd_d; rxv_q <= rxv_d;
      addr_q <= addr_d; wdat_q <= wdat_d; rx_q <= rx_d;
    end
  end

  // Requests drop on the edge that samples spi_done; X_GAP gives the idle cycle before the read.
  always_comb begin
    xs_d = xs_q; wr_d = wr_q; rd_d = rd_q; rxv_d = 1'b0;
    addr_d = addr_q; wdat_d = wdat_q; rx_d = rx_q;
    case (xs_q)
      X_IDLE: begin
        if (cs_start_i) begin
          wr_d = 1'b1; addr_d = SPI_ADDR_CS; wdat_d = cs_val_i; xs_d = X_CS;
        end else if (start_i) begin
          wr_d = 1'b1; addr_d = SPI_ADDR_DATA; wdat_d = {24'h0, tx_i}; xs_d = X_WR;
        end
      end
      X_WR:  if (spi_done_i) begin wr_d = 1'b0; xs_d = X_GAP; end
      X_GAP: begin rd_d = 1'b1; addr_d = SPI_ADDR_DATA; xs_d = X_RD; end
      X_RD: if (spi_done_i) begin
        rd_d = 1'b0; rx_d = spi_rdat_i[7:0]; rxv_d = 1'b1; xs_d = X_IDLE;
      end
      X_CS: if (spi_done_i) begin wr_d = 1'b0; rxv_d = 1'b1; xs_d = X_IDLE; end
      default: xs_d = X_IDLE;
    endcase
  end

  assign rx_o       = rx_q;
  assign rx_valid_o = rxv_q;
  assign spi_wr_o   = wr_q;
  assign spi_rd_o   = rd_q;
  assign spi_addr_o = addr_q;
  assign spi_wdat_o = wdat_q;
endmodule

// File: rtl/sd_spi_sector_reader.sv
// Reads one 512-byte SD sector in SPI mode via CMD17 and streams it out over valid/ready.
// Errors skip straight to chip-select release, one release byte, then the done pulse.
import sd_spi_pkg::*;

module sd_spi_sector_reader #(
  parameter int CS_LENGTH     = 32,
  parameter int CS_INDEX      = 0,
  parameter int BLOCK_ADDR    = 1,
  parameter int R1_TIMEOUT    = 8,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_lba,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        spi_wr,
  output logic        spi_rd,
  output logic [7:0]  spi_addr,
  output logic [31:0] spi_wdat,
  input  logic [31:0] spi_rdat,
  input  logic        spi_done
);
  localparam logic [12:0]          R1_LIM      = 13'(R1_TIMEOUT);
  localparam logic [12:0]          TOK_LIM     = 13'(TOKEN_TIMEOUT);
  localparam logic [CS_LENGTH-1:0] CS_SEL_MASK = ~(CS_LENGTH'(1) << CS_INDEX);
  localparam logic [31:0]          CS_SEL_WORD = 32'(CS_SEL_MASK);
  localparam logic [31:0]          CS_OFF_WORD = 32'({CS_LENGTH{1'b1}});

  state_e      st_q, st_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [12:0] poll_q, poll_d;
  logic        err_q, err_d, done_q, done_d, ov_q, ov_d, ol_q, ol_d;
  logic        go_q, go_d, gocs_q, gocs_d;
  logic [2:0]  code_q, code_d;
  logic [7:0]  od_q, od_d, tx_q, tx_d, rx;
  logic [31:0] lba_q, lba_d, arg, cs_val;
  logic        rx_valid;

  assign arg    = (BLOCK_ADDR != 0) ? lba_q : {lba_q[22:0], 9'b0};
  assign cs_val = (st_q == S_CS_ON) ? CS_SEL_WORD : CS_OFF_WORD;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_q <= S_IDLE; cnt_q <= 10'd0; poll_q <= 13'd0; err_q <= 1'b0; code_q <= ERR_OK;
      done_q <= 1'b0; ov_q <= 1'b0; ol_q <= 1'b0; od_q <= 8'h00; go_q <= 1'b0; gocs_q <= 1'b0;
    end else begin
      st_q <= st_d; cnt_q <= cnt_d; poll_q <= poll_d; err_q <= err_d; code_q <= code_d;
      done_q <= done_d; ov_q <= ov_d; ol_q <= ol_d; od_q <= od_d; go_q <= go_d; gocs_q <= gocs_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_q  <= tx_d;
    lba_q <= lba_d;
  end

  always_comb begin
    st_d = st_q; cnt_d = cnt_q; poll_d = poll_q; err_d = err_q; code_d = code_q;
    done_d = 1'b0; ov_d = ov_q; ol_d = ol_q; od_d = od_q; go_d = 1'b0; gocs_d = 1'b0;
    tx_d = tx_q; lba_d = lba_q;
    case (st_q)
      S_IDLE: if (cmd_valid) begin
        lba_d = cmd_lba; err_d = 1'b0; code_d = ERR_OK; gocs_d = 1'b1; st_d = S_CS_ON;
      end
      S_CS_ON: if (rx_valid) begin go_d = 1'b1; tx_d = IDLE_BYTE; st_d = S_PRE; end
      S_PRE: if (rx_valid) begin go_d = 1'b1; tx_d = CMD17; cnt_d = 10'd0; st_d = S_CMD; end
      S_CMD: if (rx_valid) begin
        go_d = 1'b1;
        if (cnt_q == 10'd5) begin
          tx_d = IDLE_BYTE; poll_d = 13'd1; st_d = S_R1;
        end else begin
          cnt_d = cnt_q + 10'd1; tx_d = cmd17_byte(cnt_d[2:0], arg);
        end
      end
      // poll_q counts polls already issued and only advances below the limit, so it never wraps.
      S_R1: if (rx_valid) begin
        if (!rx[7] && rx == 8'h00) begin
          go_d = 1'b1; tx_d = IDLE_BYTE; poll_d = 13'd1; st_d = S_TOKEN;
        end else if (!rx[7]) begin
          err_d = 1'b1; code_d = ERR_R1_BAD; gocs_d = 1'b1; st_d = S_CS_OFF;
        end else if (poll_q >= R1_LIM) begin
          err_d = 1'b1; code_d = ERR_R1_TIMEOUT; gocs_d = 1'b1; st_d = S_CS_OFF;
        end else begin
          go_d = 1'b1; tx_d = IDLE_BYTE; poll_d = poll_q + 13'd1;
        end
      end
      S_TOKEN: if (rx_valid) begin
        if (rx == TOKEN_START) begin
          go_d = 1'b1; tx_d = IDLE_BYTE; cnt_d = 10'd0; st_d = S_DATA;
        end else if (rx != IDLE_BYTE) begin
          err_d = 1'b1; code_d = ERR_TOKEN_BAD; gocs_d = 1'b1; st_d = S_CS_OFF;
        end else if (poll_q >= TOK_LIM) begin
          err_d = 1'b1; code_d = ERR_TOKEN_TIMEOUT; gocs_d = 1'b1; st_d = S_CS_OFF;
        end else begin
          go_d = 1'b1; tx_d = IDLE_BYTE; poll_d = poll_q + 13'd1;
        end
      end
      S_DATA: if (rx_valid) begin
        od_d = rx; ov_d = 1'b1; ol_d = (cnt_q == 10'd511); st_d = S_HOLD;
      end
      // The next card byte is fetched only once the held byte is consumed; cnt runs on into 512/513 for CRC.
      S_HOLD: if (out_ready) begin
        ov_d = 1'b0; ol_d = 1'b0; cnt_d = cnt_q + 10'd1; go_d = 1'b1; tx_d = IDLE_BYTE;
        st_d = (cnt_q == 10'd511) ? S_CRC : S_DATA;
      end
      S_CRC: if (rx_valid) begin
        if (cnt_q == 10'd513) begin
          gocs_d = 1'b1; st_d = S_CS_OFF;
        end else begin
          cnt_d = cnt_q + 10'd1; go_d = 1'b1; tx_d = IDLE_BYTE;
        end
      end
      S_CS_OFF: if (rx_valid) begin go_d = 1'b1; tx_d = IDLE_BYTE; st_d = S_TAIL; end
      S_TAIL:   if (rx_valid) begin done_d = 1'b1; st_d = S_FIN; end
      S_FIN:    st_d = S_IDLE;
      default:  st_d = S_IDLE;
    endcase
  end

  sd_spi_byte_xfer u_xfer (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (go_q),
    .tx_i       (tx_q),
    .cs_start_i (gocs_q),
    .cs_val_i   (cs_val),
    .rx_o       (rx),
    .rx_valid_o (rx_valid),
    .spi_wr_o   (spi_wr),
    .spi_rd_o   (spi_rd),
    .spi_addr_o (spi_addr),
    .spi_wdat_o (spi_wdat),
    .spi_rdat_i (spi_rdat),
    .spi_done_i (spi_done)
  );

  assign cmd_ready = (st_q == S_IDLE);
  assign busy      = (st_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
endmodule

// File: tb/tb_sd_spi_sector_reader.sv
// Randomized bench: a behavioural SD card behind a ctrl-port responder, a stream sink and a
// per-command expectation model. Two DUTs share the bench (block and byte addressing).
module tb_sd_spi_sector_reader;
  localparam int R1_TO  = 8;
  localparam int TOK_TO = 4096;

  logic        clk, resetn, cmd_valid, out_ready, spi_done, sel;
  logic [31:0] cmd_lba, spi_rdat;

  logic        cmd_ready0, out_valid0, out_last0, busy0, done0, err0, spi_wr0, spi_rd0;
  logic        cmd_ready1, out_valid1, out_last1, busy1, done1, err1, spi_wr1, spi_rd1;
  logic [7:0]  out_data0, out_data1, spi_addr0, spi_addr1;
  logic [2:0]  err_code0, err_code1;
  logic [31:0] spi_wdat0, spi_wdat1;

  logic        cmd_ready, out_valid, out_last, busy, done, err, spi_wr, spi_rd;
  logic [7:0]  out_data, spi_addr;
  logic [2:0]  err_code;
  logic [31:0] spi_wdat;
  logic        cv0, cv1, sd0, sd1;

  assign cv0 = cmd_valid & ~sel;   assign cv1 = cmd_valid & sel;
  assign sd0 = spi_done & ~sel;    assign sd1 = spi_done & sel;
  assign cmd_ready = sel ? cmd_ready1 : cmd_ready0;
  assign out_valid = sel ? out_valid1 : out_valid0;
  assign out_last  = sel ? out_last1  : out_last0;
  assign out_data  = sel ? out_data1  : out_data0;
  assign busy      = sel ? busy1      : busy0;
  assign done      = sel ? done1      : done0;
  assign err       = sel ? err1       : err0;
  assign err_code  = sel ? err_code1  : err_code0;
  assign spi_wr    = sel ? spi_wr1    : spi_wr0;
  assign spi_rd    = sel ? spi_rd1    : spi_rd0;
  assign spi_addr  = sel ? spi_addr1  : spi_addr0;
  assign spi_wdat  = sel ? spi_wdat1  : spi_wdat0;

  sd_spi_sector_reader dut0 (
    .clk(clk), .resetn(resetn), .cmd_valid(cv0), .cmd_ready(cmd_ready0), .cmd_lba(cmd_lba),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0),
    .busy(busy0), .done(done0), .err(err0), .err_code(err_code0),
    .spi_wr(spi_wr0), .spi_rd(spi_rd0), .spi_addr(spi_addr0), .spi_wdat(spi_wdat0),
    .spi_rdat(spi_rdat), .spi_done(sd0));

  sd_spi_sector_reader #(.BLOCK_ADDR(0)) dut1 (
    .clk(clk), .resetn(resetn), .cmd_valid(cv1), .cmd_ready(cmd_ready1), .cmd_lba(cmd_lba),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1),
    .busy(busy1), .done(done1), .err(err1), .err_code(err_code1),
    .spi_wr(spi_wr1), .spi_rd(spi_rd1), .spi_addr(spi_addr1), .spi_wdat(spi_wdat1),
    .spi_rdat(spi_rdat), .spi_done(sd1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Card state
  int          cphase, cmd_len, ph1, ph2, di, crc_n, r1_after, tok_after;
  logic [7:0]  r1_val, tok_val, last_tx;
  logic [7:0]  data_mem [512];
  logic [47:0] cmd_seen;
  logic [31:0] cs_first, cs_last;
  int          cs_n, xfer_after_cs, hs_bad;

  // Sink/monitor state
  logic [7:0]  rxq[$];
  int          ov_n, done_n, last_n, last_pos, stab_bad, stall_mode;
  logic        stalled, st_last;
  logic [7:0]  st_data;

  task automatic cs_write(input logic [31:0] v);
    cs_n++;
    if (cs_n == 1) cs_first = v;
    cs_last = v;
    xfer_after_cs = 0;
    if (v != 32'hFFFF_FFFF) begin
      cphase = 0; cmd_len = 0; ph1 = 0; ph2 = 0; di = 0; crc_n = 0; cmd_seen = '0;
    end else cphase = 9;
  endtask

  task automatic card_read(output logic [7:0] b);
    b = 8'hFF;
    case (cphase)
      0: if (cmd_len > 0 || last_tx == 8'h51) begin
        cmd_seen = {cmd_seen[39:0], last_tx};
        cmd_len++;
        if (cmd_len == 6) cphase = 1;
      end
      1: begin
        ph1++;
        if (r1_after >= 0 && ph1 > r1_after) begin b = r1_val; cphase = (r1_val == 8'h00) ? 2 : 9; end
      end
      2: begin
        ph2++;
        if (tok_after >= 0 && ph2 > tok_after) begin b = tok_val; cphase = (tok_val == 8'hFE) ? 3 : 9; end
      end
      3: begin
        b = data_mem[di]; di++;
        if (di == 512) cphase = 4;
      end
      4: begin
        b = 8'($urandom); crc_n++;
        if (crc_n == 2) cphase = 9;
      end
      default: ;
    endcase
  endtask

  // Ctrl-port responder with random completion latency.
  initial begin : responder
    int wcnt, wtgt;
    logic done_prev;
    logic [7:0] b;
    spi_done = 1'b0; spi_rdat = '0; wcnt = 0; wtgt = 0; done_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (spi_wr && spi_rd) hs_bad++;
      if (done_prev && (spi_wr || spi_rd)) hs_bad++;
      done_prev = 1'b0;
      if (spi_done) spi_done = 1'b0;
      else if (spi_wr || spi_rd) begin
        if (wcnt >= wtgt) begin
          if (spi_wr && spi_addr == 8'h04) cs_write(spi_wdat);
          else if (spi_wr) begin last_tx = spi_wdat[7:0]; xfer_after_cs++; end
          else begin card_read(b); spi_rdat = {24'($urandom), b}; end
          spi_done = 1'b1; done_prev = 1'b1; wcnt = 0; wtgt = $urandom_range(0, 1);
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Stream sink and done monitor.
  initial begin : sink
    out_ready = 1'b1; stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (stalled && (!out_valid || out_data != st_data || out_last != st_last)) stab_bad++;
      out_ready = (stall_mode != 0) ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (out_valid) ov_n++;
      if (out_valid && out_ready) begin
        rxq.push_back(out_data);
        if (out_last) begin last_n++; last_pos = rxq.size() - 1; end
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1; st_data = out_data; st_last = out_last;
      end else stalled = 1'b0;
      if (done) done_n++;
    end
  end

  function automatic int exp_code(int r1a, logic [7:0] r1v, int toka, logic [7:0] tokv);
    if (r1a < 0 || r1a + 1 > R1_TO) return 1;
    if (r1v != 8'h00) return 2;
    if (toka < 0 || toka + 1 > TOK_TO) return 4;
    if (tokv != 8'hFE) return 3;
    return 0;
  endfunction

  task automatic start_cmd(input logic s, input logic [31:0] lba);
    @(negedge clk);
    sel = s; rxq.delete(); ov_n = 0; done_n = 0; last_n = 0; last_pos = -1; stab_bad = 0;
    hs_bad = 0; cs_n = 0; xfer_after_cs = 0; cmd_seen = '0; cs_first = '0; cs_last = '0;
    cmd_valid = 1'b1; cmd_lba = lba;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_test(input string tag, input logic s, input logic [31:0] lba,
                          input int r1a, input logic [7:0] r1v, input int toka,
                          input logic [7:0] tokv, input int stall, input int rnd, input int poke);
    int ec, bad;
    logic [31:0] arg;
    r1_after = r1a; r1_val = r1v; tok_after = toka; tok_val = tokv; stall_mode = stall;
    for (int i = 0; i < 512; i++) data_mem[i] = (rnd != 0) ? 8'($urandom) : 8'(i);
    ec  = exp_code(r1a, r1v, toka, tokv);
    arg = s ? (lba << 9) : lba;
    start_cmd(s, lba);
    if (poke != 0) begin
      repeat (40) @(negedge clk);
      check_eq({tag, "/ready_busy"}, cmd_ready, 0);
      cmd_valid = 1'b1; cmd_lba = ~lba;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    for (int i = 0; i < 60000 && done_n == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_eq({tag, "/done_cnt"}, done_n, 1);
    check_eq({tag, "/err_code"}, err_code, ec);
    check_eq({tag, "/err"}, err, ec != 0);
    check_eq({tag, "/cmd_bytes"}, cmd_seen, {8'h51, arg, 8'h01});
    check_eq({tag, "/cs_n"}, cs_n, 2);
    check_eq({tag, "/cs_sel"}, cs_first, 32'hFFFF_FFFE);
    check_eq({tag, "/cs_rel"}, cs_last, 32'hFFFF_FFFF);
    check_eq({tag, "/tail_xfers"}, xfer_after_cs, 1);
    check_eq({tag, "/handshake"}, hs_bad, 0);
    check_eq({tag, "/idle_ready"}, {cmd_ready, busy}, 2'b10);
    if (ec == 0) begin
      bad = 0;
      for (int i = 0; i < rxq.size() && i < 512; i++) if (rxq[i] !== data_mem[i]) bad++;
      check_eq({tag, "/n_bytes"}, rxq.size(), 512);
      check_eq({tag, "/bad_bytes"}, bad, 0);
      check_eq({tag, "/last"}, {32'(last_n), 32'(last_pos)}, {32'd1, 32'd511});
      check_eq({tag, "/stable"}, stab_bad, 0);
    end else begin
      check_eq({tag, "/no_valid"}, ov_n, 0);
      if (ec == 1) check_eq({tag, "/r1_polls"}, ph1, R1_TO);
      if (ec == 4) check_eq({tag, "/tok_polls"}, ph2, TOK_TO);
    end
  endtask

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bad;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_lba = '0; sel = 1'b0; stall_mode = 0;
    hs_bad = 0; ov_n = 0; done_n = 0; cphase = 9; last_tx = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst/cmd_ready", cmd_ready, 1);
    check_eq("rst/flags", {busy, done, err, out_valid, out_last, spi_wr, spi_rd}, 7'b0);
    check_eq("rst/err_code", err_code, 0);
    check_eq("rst/data", {out_data, spi_addr, spi_wdat}, 48'h0);
    @(negedge clk);
    resetn = 1'b1;

    run_test("t1_basic",    0, 32'd7, 2, 8'h00, 5, 8'hFE, 0, 0, 0);
    run_test("t2_stall",    0, 32'd7, 2, 8'h00, 5, 8'hFE, 1, 0, 0);
    run_test("t3_r1_to",    0, $urandom, -1, 8'h00, 5, 8'hFE, 0, 1, 0);
    run_test("t3_r1_edge",  0, $urandom, R1_TO - 1, 8'h00, 3, 8'hFE, 0, 1, 0);
    run_test("t4_r1_bad",   0, $urandom, $urandom_range(0, 3), 8'h04, 5, 8'hFE, 0, 1, 0);
    run_test("t4_tok_bad",  0, $urandom, 2, 8'h00, $urandom_range(0, 20), 8'h08, 0, 1, 0);
    run_test("t4_tok_to",   0, $urandom, 1, 8'h00, -1, 8'hFE, 0, 1, 0);

    // Reset in the middle of the data phase, then a clean read.
    r1_after = 1; r1_val = 8'h00; tok_after = 3; tok_val = 8'hFE; stall_mode = 0;
    for (int i = 0; i < 512; i++) data_mem[i] = 8'($urandom);
    start_cmd(0, $urandom);
    for (int i = 0; i < 20000 && rxq.size() < 100; i++) @(negedge clk);
    check_eq("t5/reached_100", rxq.size() >= 100, 1);
    bad = 0;
    for (int i = 0; i < rxq.size() && i < 512; i++) if (rxq[i] !== data_mem[i]) bad++;
    check_eq("t5/prefix", bad, 0);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5/req_drop", {spi_wr, spi_rd}, 2'b00);
    check_eq("t5/ready", {cmd_ready, busy, out_valid}, 3'b100);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    run_test("t5_after",    0, $urandom, $urandom_range(0, 7), 8'h00, $urandom_range(0, 40), 8'hFE, 1, 1, 0);

    run_test("t6_byteaddr", 1, 32'd3, 2, 8'h00, 5, 8'hFE, 0, 1, 1);
    run_test("t7_random",   1, $urandom, $urandom_range(0, 7), 8'h00, $urandom_range(0, 30), 8'hFE, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
